dvp_frame_sequencer: RTL and testbench
======================================

Name: dvp_frame_sequencer

Overview:
Synthesizable DVP timing master that schedules frame transmission for the ISP datapath. It generates href/hsync/vsync, pulls pixels from an upstream pixel source (FWFT FIFO or frame reader) with a request/valid handshake, and runs a programmable number of frames or runs continuously. Software or a bench controller drives it with start/stop pulses. It reports busy, per-frame completion, frame count and a sticky underflow flag.

Parameters:
BITS, 8, pixel width (8/16/24/32)
H_FRONT, 50, hsync front porch (pixel clocks)
H_PULSE, 100, hsync pulse width
H_BACK, 50, hsync back porch
H_DISP, 1280, active pixels per line
V_FRONT, 10, vsync front porch (lines)
V_PULSE, 20, vsync pulse width
V_BACK, 10, vsync back porch
V_DISP, 960, active lines per frame
H_POL, 0, hsync level during pulse
V_POL, 1, vsync level during pulse

Ports:
xclk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: begin sequence
stop  in  1  one-cycle pulse: graceful stop after current frame
cfg_frames  in  16  frames to send; 0 = continuous; sampled on accepted start
pix_req  out  1  pixel request (combinational from state and counters)
pix_valid  in  1  upstream has pixel on pix_data this cycle
pix_data  in  BITS  upstream pixel
href  out  1  line-valid
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
data  out  BITS  pixel out; 0 when href=0
busy  out  1  state is RUN
frame_done  out  1  one-cycle pulse at end of each frame
frame_cnt  out  16  frames completed since last accepted start
underflow  out  1  sticky: a requested pixel was not valid

Behaviour:
- H_TOTAL = sum of H params, V_TOTAL = sum of V params; both must be < 65536. pix_cnt/line_cnt are 16-bit.
- Reset (async): state IDLE, counters 0, href=0, hsync=~H_POL, vsync=~V_POL, data=0, busy=0, frame_done=0, frame_cnt=0, underflow=0, stop_pend=0.
- States: IDLE, RUN.
- IDLE: counters held at 0; outputs at reset values except frame_cnt/underflow hold. start=1 -> RUN; latch cfg_frames into frames_left, clear frame_cnt, underflow, stop_pend. stop in IDLE is ignored; start+stop in the same cycle in IDLE -> start accepted, stop dropped.
- RUN: the counters start at (0,0) on the cycle after the start edge. pix_cnt wraps at H_TOTAL-1. line_cnt increments on that wrap and itself wraps at V_TOTAL-1. start is ignored. stop sets stop_pend.
- Active region: pix_cnt >= H_FRONT+H_PULSE+H_BACK and line_cnt >= V_FRONT+V_PULSE+V_BACK. pix_req = RUN && active.
- Registered outputs, 1-cycle latency from counters:
  - href <= RUN && active.
  - hsync <= H_POL while H_FRONT <= pix_cnt < H_FRONT+H_PULSE, else ~H_POL.
  - vsync <= V_POL while V_FRONT <= line_cnt < V_FRONT+V_PULSE, else ~V_POL.
  - data <= (pix_req && pix_valid) ? pix_data : 0.
- Handshake: a pixel is consumed only in a cycle with pix_req=1 && pix_valid=1. pix_req=1 with pix_valid=0 sets underflow, outputs a 0 pixel, and timing does not stall. pix_valid without pix_req is ignored.
- End of frame (pix_cnt=H_TOTAL-1 && line_cnt=V_TOTAL-1 in RUN): frame_done pulses high on the next cycle; frame_cnt increments (saturates at 0xFFFF). If stop_pend, stop arriving that same cycle, or (cfg_frames!=0 && frame_cnt+1 == latched frames) -> IDLE. Otherwise the counters wrap to (0,0) and RUN continues.
- busy is registered and equals (state==RUN).
- Reset asserted mid-frame: all outputs return to reset values immediately; no frame_done pulse.

Test Plan:
Test parameters for all scenarios: H=2/3/1/4 (H_TOTAL=10), V=1/2/1/3 (V_TOTAL=7), 70 cycles per frame, H_POL=0, V_POL=1, BITS=8.
1. cfg_frames=2, start, pix_valid=1 -> busy high 140 cycles; frame_done pulses 70 and 140 cycles after start; frame_cnt=2; 12 href cycles per frame; hsync low 3 cycles per line; vsync high 20 cycles per frame.
2. Ramp source 0x00.. with pix_valid=1 -> data = 0x00..0x0B in href cycles, 0 elsewhere; second frame data = 0x0C..0x17; underflow=0.
3. Deassert pix_valid on the 5th pix_req of frame 1 -> that pixel data=0; underflow=1 and stays 1 until the next start; line timing unchanged.
4. cfg_frames=0, stop pulse mid-frame 3 -> frame 3 completes; frame_cnt=3; busy drops after the 3rd frame_done; no 4th frame.
5. start+stop in the same cycle while IDLE -> runs cfg_frames=1 to completion. start pulsed while busy -> ignored, frame_cnt unaffected.
6. rst_n low during line 5 of frame 1 -> href=0, hsync=1, vsync=0, busy=0, frame_cnt=0 immediately. A new start after release produces a full correct frame.

Source files
------------

// File: rtl/dvp_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// dvp_frame_sequencer_if
// Groups the upstream pixel handshake and the outgoing DVP video bus.
//   pix_req   : sequencer asks for a pixel this cycle
//   pix_valid : upstream has a pixel on pix_data this cycle
//   pix_data  : upstream pixel
//   href      : line-valid
//   hsync     : horizontal sync
//   vsync     : vertical sync
//   data      : outgoing pixel, 0 outside href
// The master modport belongs to the sequencer. The slave modport belongs to
// the pixel source and video consumer side.
// ---------------------------------------------------------------------------
interface dvp_frame_sequencer_if #(
  parameter int BITS = 8
) ();
  logic            pix_req;
  logic            pix_valid;
  logic [BITS-1:0] pix_data;
  logic            href;
  logic            hsync;
  logic            vsync;
  logic [BITS-1:0] data;

  modport master (
    output pix_req,
    input  pix_valid,
    input  pix_data,
    output href,
    output hsync,
    output vsync,
    output data
  );

  modport slave (
    input  pix_req,
    output pix_valid,
    output pix_data,
    input  href,
    input  hsync,
    input  vsync,
    input  data
  );
endinterface

// File: rtl/dvp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// dvp_frame_sequencer
// DVP timing master. It walks a pixel/line counter raster and generates
// href/hsync/vsync. During the active window it pulls pixels from an
// upstream source through a request/valid handshake. It sends a latched
// number of frames, or runs continuously until a graceful stop.
//   xclk, rst_n  : pixel clock, asynchronous active-low reset
//   start, stop  : one-cycle control pulses
//   cfg_frames   : frames per run (0 = continuous), sampled on accepted start
//   bus          : pixel handshake and DVP outputs (master side)
//   busy         : sequencer is running
//   frame_done   : one-cycle pulse after the last pixel clock of a frame
//   frame_cnt    : frames completed since the last accepted start
//   underflow    : sticky, a requested pixel was not valid
// ---------------------------------------------------------------------------
module dvp_frame_sequencer #(
  parameter int BITS    = 8,
  parameter int H_FRONT = 50,
  parameter int H_PULSE = 100,
  parameter int H_BACK  = 50,
  parameter int H_DISP  = 1280,
  parameter int V_FRONT = 10,
  parameter int V_PULSE = 20,
  parameter int V_BACK  = 10,
  parameter int V_DISP  = 960,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b1
) (
  input  logic                         xclk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [15:0]                  cfg_frames,
  dvp_frame_sequencer_if.master        bus,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_cnt,
  output logic                         underflow
);

  localparam logic [15:0] H_LAST   = 16'(H_FRONT + H_PULSE + H_BACK + H_DISP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_FRONT + V_PULSE + V_BACK + V_DISP - 1);
  localparam logic [15:0] H_ACT    = 16'(H_FRONT + H_PULSE + H_BACK);
  localparam logic [15:0] V_ACT    = 16'(V_FRONT + V_PULSE + V_BACK);
  localparam logic [15:0] HS_START = 16'(H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_FRONT + H_PULSE);
  localparam logic [15:0] VS_START = 16'(V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_FRONT + V_PULSE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     pix_cnt_q, pix_cnt_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic [15:0]     frames_left_q, frames_left_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            underflow_q, underflow_d;
  logic            stop_pend_q, stop_pend_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q;
  logic            href_q, href_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic [BITS-1:0] data_q, data_d;
  logic            active;
  logic            pix_req;

  // State register. It holds the raster counters, control state and all
  // registered outputs. Sync levels reset to their inactive polarity.
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      frames_left_q <= '0;
      frame_cnt_q   <= '0;
      underflow_q   <= 1'b0;
      stop_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      href_q        <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      frames_left_q <= frames_left_d;
      frame_cnt_q   <= frame_cnt_d;
      underflow_q   <= underflow_d;
      stop_pend_q   <= stop_pend_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= (state_d == RUN);
      href_q        <= href_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      data_q        <= data_d;
    end
  end

  // Next-state logic. In IDLE the counters are held at zero, so the first
  // RUN cycle sits at (0,0). At the end of a frame the run stops when a stop
  // is pending or arrives now, or when the latched frame budget is used up.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    frames_left_d = frames_left_q;
    frame_cnt_d   = frame_cnt_q;
    underflow_d   = underflow_q;
    stop_pend_d   = stop_pend_q;
    frame_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        if (start) begin
          state_d       = RUN;
          frames_left_d = cfg_frames;
          frame_cnt_d   = '0;
          underflow_d   = 1'b0;
          stop_pend_d   = 1'b0;
        end
      end
      RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (pix_req && !bus.pix_valid) underflow_d = 1'b1;
        if (pix_cnt_q == H_LAST) begin
          pix_cnt_d = '0;
          if (line_cnt_q == V_LAST) begin
            line_cnt_d   = '0;
            frame_done_d = 1'b1;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            if (stop_pend_q || stop ||
                ((frames_left_q != 16'd0) && ((frame_cnt_q + 16'd1) == frames_left_q))) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
            end
          end else begin
            line_cnt_d = line_cnt_q + 16'd1;
          end
        end else begin
          pix_cnt_d = pix_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. It decodes the raster position into the active window and
  // the sync pulses. A missing pixel becomes a 0 instead of stalling timing.
  always_comb begin
    active  = (pix_cnt_q >= H_ACT) && (line_cnt_q >= V_ACT);
    pix_req = (state_q == RUN) && active;
    href_d  = pix_req;
    hsync_d = ~H_POL;
    vsync_d = ~V_POL;
    if (state_q == RUN) begin
      if ((pix_cnt_q >= HS_START) && (pix_cnt_q < HS_END))   hsync_d = H_POL;
      if ((line_cnt_q >= VS_START) && (line_cnt_q < VS_END)) vsync_d = V_POL;
    end
    data_d = (pix_req && bus.pix_valid) ? bus.pix_data : '0;
  end

  assign bus.pix_req = pix_req;
  assign bus.href    = href_q;
  assign bus.hsync   = hsync_q;
  assign bus.vsync   = vsync_q;
  assign bus.data    = data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvp_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dvp_frame_sequencer
// Directed bench for dvp_frame_sequencer on a 10x7 raster (70 clocks/frame).
// A ramp source pushes each pixel it offers into a scoreboard queue. A
// monitor pops that queue on every href cycle. Expected frame_done events
// (cycle offset from start, frame count) are queued when a run is launched.
// ---------------------------------------------------------------------------
module tb_dvp_frame_sequencer;

  typedef struct {
    int offset;
    int cnt;
  } doneExp_t;

  logic        xclk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] cfgFrames;
  logic        busy;
  logic        frameDone;
  logic [15:0] frameCnt;
  logic        underflow;

  int          checks;
  int          errors;
  int          cycleNo;
  int          startCycle;
  int          busyCycles;
  int          reqIdx;
  int          dropIdx;
  logic [7:0]  ramp;
  logic [7:0]  lastData;
  logic [7:0]  pixQ[$];
  doneExp_t    doneQ[$];

  dvp_frame_sequencer_if #(.BITS(8)) bus ();

  dvp_frame_sequencer #(
    .BITS(8),
    .H_FRONT(2), .H_PULSE(3), .H_BACK(1), .H_DISP(4),
    .V_FRONT(1), .V_PULSE(2), .V_BACK(1), .V_DISP(3),
    .H_POL(1'b0), .V_POL(1'b1)
  ) dut (
    .xclk(xclk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .cfg_frames(cfgFrames),
    .bus(bus),
    .busy(busy),
    .frame_done(frameDone),
    .frame_cnt(frameCnt),
    .underflow(underflow)
  );

  // Free-running pixel clock and a cycle counter used to time events
  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  initial cycleNo = 0;
  always @(posedge xclk) cycleNo++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, actual, expected, cycleNo);
    end
  endtask

  // Launch a run and queue the frame_done events it should produce
  task automatic applyStimulus(input logic [15:0] frames, input logic withStop,
                               input int expectDone);
    @(negedge xclk);
    ramp       = 8'h00;
    reqIdx     = 0;
    busyCycles = 0;
    start      = 1'b1;
    stop       = withStop;
    cfgFrames  = frames;
    startCycle = cycleNo + 1;
    for (int k = 1; k <= expectDone; k++) doneQ.push_back('{70 * k, k});
    @(negedge xclk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulseStartOnly(input logic [15:0] frames);
    @(negedge xclk);
    start     = 1'b1;
    cfgFrames = frames;
    @(negedge xclk);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    @(negedge xclk);
    stop = 1'b1;
    @(negedge xclk);
    stop = 1'b0;
  endtask

  task automatic waitOffset(input int offset);
    while (cycleNo < startCycle + offset) @(negedge xclk);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge xclk);
    while (busy && n < budget) begin
      @(negedge xclk);
      n++;
    end
    checkOutput("run completes within budget", 32'(busy), 32'd0);
    repeat (3) @(negedge xclk);
  endtask

  // Pixel source. It offers a ramp on every request and drops the request
  // numbered dropIdx. It records what each href cycle should carry.
  always @(negedge xclk) begin
    if (rst_n) begin
      if (bus.pix_req) begin
        if (reqIdx == dropIdx) begin
          bus.pix_valid = 1'b0;
          bus.pix_data  = 8'hEE;
          pixQ.push_back(8'h00);
        end else begin
          bus.pix_valid = 1'b1;
          bus.pix_data  = ramp;
          pixQ.push_back(ramp);
          ramp = ramp + 8'd1;
        end
        reqIdx++;
      end else begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'h5A;
      end
    end
  end

  // Monitor. It compares pixels against the scoreboard, tallies per-frame
  // timing and checks each frame_done against the queued expectation.
  initial begin
    int       hrefCnt;
    int       hsLow;
    int       vsHigh;
    doneExp_t e;
    hrefCnt = 0;
    hsLow   = 0;
    vsHigh  = 0;
    forever begin
      @(posedge xclk);
      #1;
      if (!rst_n) begin
        hrefCnt = 0;
        hsLow   = 0;
        vsHigh  = 0;
      end else begin
        if (busy) busyCycles++;
        if (bus.href) begin
          hrefCnt++;
          if (pixQ.size() == 0) begin
            checkOutput("href with no pixel pending", 32'(bus.href), 32'd0);
          end else begin
            checkOutput("pixel data", 32'(bus.data), 32'(pixQ.pop_front()));
            lastData = bus.data;
          end
        end else begin
          checkOutput("blank data", 32'(bus.data), 32'd0);
        end
        if (!bus.hsync) hsLow++;
        if (bus.vsync) vsHigh++;
        if (frameDone) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpected frame_done", 32'(frameDone), 32'd0);
          end else begin
            e = doneQ.pop_front();
            checkOutput("frame_done offset", 32'(cycleNo - startCycle), 32'(e.offset));
            checkOutput("frame_cnt at done", 32'(frameCnt), 32'(e.cnt));
          end
          checkOutput("href cycles per frame", 32'(hrefCnt), 32'd12);
          checkOutput("hsync low cycles per frame", 32'(hsLow), 32'd21);
          checkOutput("vsync high cycles per frame", 32'(vsHigh), 32'd20);
          hrefCnt = 0;
          hsLow   = 0;
          vsHigh  = 0;
        end
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    busyCycles    = 0;
    startCycle    = 0;
    reqIdx        = 0;
    dropIdx       = -1;
    ramp          = 8'h00;
    lastData      = 8'h00;
    rst_n         = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    cfgFrames     = 16'd0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;

    // Reset values
    repeat (3) @(negedge xclk);
    checkOutput("reset href", 32'(bus.href), 32'd0);
    checkOutput("reset hsync", 32'(bus.hsync), 32'd1);
    checkOutput("reset vsync", 32'(bus.vsync), 32'd0);
    checkOutput("reset data", 32'(bus.data), 32'd0);
    checkOutput("reset pix_req", 32'(bus.pix_req), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset frame_done", 32'(frameDone), 32'd0);
    checkOutput("reset frame_cnt", 32'(frameCnt), 32'd0);
    checkOutput("reset underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge xclk);

    // Two frames with a ramp source: pixels 0x00..0x17, no underflow
    $display("[TB] two-frame ramp run");
    applyStimulus(16'd2, 1'b0, 2);
    checkOutput("busy after start", 32'(busy), 32'd1);
    waitIdle(400);
    checkOutput("busy cycles 2 frames", 32'(busyCycles), 32'd140);
    checkOutput("frame_cnt 2 frames", 32'(frameCnt), 32'd2);
    checkOutput("underflow clean run", 32'(underflow), 32'd0);
    checkOutput("last pixel frame 2", 32'(lastData), 32'h17);
    checkOutput("pixel queue drained", 32'(pixQ.size()), 32'd0);
    checkOutput("done queue drained", 32'(doneQ.size()), 32'd0);

    // Drop the 5th requested pixel of frame 1
    $display("[TB] underflow run");
    dropIdx = 4;
    applyStimulus(16'd2, 1'b0, 2);
    waitOffset(50);
    checkOutput("underflow before drop", 32'(underflow), 32'd0);
    waitOffset(60);
    checkOutput("underflow after drop", 32'(underflow), 32'd1);
    waitIdle(400);
    checkOutput("underflow sticky", 32'(underflow), 32'd1);
    checkOutput("frame_cnt underflow run", 32'(frameCnt), 32'd2);
    dropIdx = -1;

    // Continuous mode with a stop in frame 3
    $display("[TB] continuous run with stop");
    applyStimulus(16'd0, 1'b0, 3);
    checkOutput("underflow cleared by start", 32'(underflow), 32'd0);
    waitOffset(175);
    pulseStop();
    waitIdle(600);
    checkOutput("busy cycles 3 frames", 32'(busyCycles), 32'd210);
    checkOutput("frame_cnt after stop", 32'(frameCnt), 32'd3);
    repeat (100) @(negedge xclk);
    checkOutput("no 4th frame busy", 32'(busy), 32'd0);
    checkOutput("frame_cnt holds in idle", 32'(frameCnt), 32'd3);
    checkOutput("no extra frame_done pending", 32'(doneQ.size()), 32'd0);

    // Start+stop together in idle, then a start while busy
    $display("[TB] start+stop and start while busy");
    applyStimulus(16'd1, 1'b1, 1);
    waitOffset(30);
    pulseStartOnly(16'd5);
    waitIdle(400);
    checkOutput("busy cycles single frame", 32'(busyCycles), 32'd70);
    checkOutput("frame_cnt single frame", 32'(frameCnt), 32'd1);
    repeat (80) @(negedge xclk);
    checkOutput("stays idle after single frame", 32'(busy), 32'd0);

    // Reset during line 5 of frame 1, then a clean frame
    $display("[TB] reset mid-frame");
    applyStimulus(16'd1, 1'b0, 0);
    waitOffset(53);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset href", 32'(bus.href), 32'd0);
    checkOutput("mid reset hsync", 32'(bus.hsync), 32'd1);
    checkOutput("mid reset vsync", 32'(bus.vsync), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset frame_cnt", 32'(frameCnt), 32'd0);
    checkOutput("mid reset data", 32'(bus.data), 32'd0);
    @(negedge xclk);
    pixQ.delete();
    doneQ.delete();
    repeat (2) @(negedge xclk);
    rst_n = 1'b1;
    repeat (2) @(negedge xclk);
    applyStimulus(16'd1, 1'b0, 1);
    waitIdle(400);
    checkOutput("busy cycles after reset", 32'(busyCycles), 32'd70);
    checkOutput("frame_cnt after reset run", 32'(frameCnt), 32'd1);
    checkOutput("last pixel after reset run", 32'(lastData), 32'h0B);
    checkOutput("pixel queue drained after reset run", 32'(pixQ.size()), 32'd0);
    checkOutput("done queue drained after reset run", 32'(doneQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
